// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: loads a 16-word message block, then issues one
// aligned (t, K[t], W[t]) triple per round while expanding the message schedule.
module sha256_round_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        msg_valid,
    input  logic [31:0] msg_data,
    output logic        msg_ready,
    output logic [5:0]  rom_addr,
    input  logic [31:0] rom_k,
    output logic        round_valid,
    input  logic        round_ready,
    output logic [5:0]  round_idx,
    output logic [31:0] round_k,
    output logic [31:0] round_w,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        DONE
    } state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  wordCnt_q, wordCnt_d;
    logic [5:0]  t_q, t_d;
    logic [5:0]  tNext;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] schedNext;

    function automatic logic [31:0] smallSigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] smallSigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // win[0] is always W[t]; the slot entering at win[15] is W[t+16].
    assign schedNext = smallSigma1(win_q[14]) + win_q[9] + smallSigma0(win_q[1]) + win_q[0];
    assign tNext     = (t_q == LAST_T) ? 6'd0 : t_q + 6'd1;

    assign round_idx = t_q;
    assign round_k   = rom_k;
    assign round_w   = win_q[0];
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        wordCnt_d   = wordCnt_q;
        t_d         = t_q;
        win_d       = win_q;
        msg_ready   = 1'b0;
        round_valid = 1'b0;
        rom_addr    = 6'd0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    wordCnt_d = 4'd0;
                end
            end
            LOAD: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
                    win_d[15] = msg_data;
                    wordCnt_d = wordCnt_q + 4'd1;
                    if (wordCnt_q == 4'd15) begin
                        state_d = ROUND;
                        t_d     = 6'd0;
                    end
                end
            end
            ROUND: begin
                round_valid = 1'b1;
                // The ROM registers its address, so look one round ahead only when this one retires.
                rom_addr    = round_ready ? tNext : t_q;
                if (round_ready) begin
                    for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
                    win_d[15] = schedNext;
                    t_d       = tNext;
                    if (t_q == LAST_T) state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wordCnt_q <= 4'd0;
            t_q       <= 6'd0;
            for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
        end else begin
            state_q   <= state_d;
            wordCnt_q <= wordCnt_d;
            t_q       <= t_d;
            win_q     <= win_d;
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: a 64-round and a 16-round instance,
// each with a registered K ROM, checked against a plain-arithmetic SHA-256 schedule model.
module tb_sha256_round_ctrl;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        start, msgValid, roundReady, sel;
    logic [31:0] msgData;
    logic        start64, start16;

    logic        msgReady64, roundValid64, busy64, done64;
    logic [5:0]  romAddr64, roundIdx64;
    logic [31:0] romK64, roundK64, roundW64;
    logic        msgReady16, roundValid16, busy16, done16;
    logic [5:0]  romAddr16, roundIdx16;
    logic [31:0] romK16, roundK16, roundW16;

    logic        oMsgReady, oRoundValid, oBusy, oDone;
    logic [5:0]  oRomAddr, oRoundIdx;
    logic [31:0] oRoundK, oRoundW;

    logic [31:0] blockMsg [16];
    logic [31:0] w16, w17, lastK;
    int          compareCount = 0;
    int          failCount = 0;

    always #5 clk = ~clk;

    // sel picks which instance is exercised; the other only ever sees start=0.
    assign start64 = start & ~sel;
    assign start16 = start & sel;

    assign oMsgReady   = sel ? msgReady16   : msgReady64;
    assign oRoundValid = sel ? roundValid16 : roundValid64;
    assign oBusy       = sel ? busy16       : busy64;
    assign oDone       = sel ? done16       : done64;
    assign oRomAddr    = sel ? romAddr16    : romAddr64;
    assign oRoundIdx   = sel ? roundIdx16   : roundIdx64;
    assign oRoundK     = sel ? roundK16     : roundK64;
    assign oRoundW     = sel ? roundW16     : roundW64;

    sha256_round_ctrl #(.ROUNDS(64)) dut (
        .clk(clk), .reset(reset), .start(start64), .msg_valid(msgValid), .msg_data(msgData),
        .msg_ready(msgReady64), .rom_addr(romAddr64), .rom_k(romK64), .round_valid(roundValid64),
        .round_ready(roundReady), .round_idx(roundIdx64), .round_k(roundK64), .round_w(roundW64),
        .busy(busy64), .done(done64)
    );

    sha256_round_ctrl #(.ROUNDS(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .msg_valid(msgValid), .msg_data(msgData),
        .msg_ready(msgReady16), .rom_addr(romAddr16), .rom_k(romK16), .round_valid(roundValid16),
        .round_ready(roundReady), .round_idx(roundIdx16), .round_k(roundK16), .round_w(roundW16),
        .busy(busy16), .done(done16)
    );

    // Registered K ROMs, cleared by the same reset as the controllers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            romK64 <= 32'd0;
            romK16 <= 32'd0;
        end else begin
            romK64 <= K_TAB[romAddr64];
            romK16 <= K_TAB[romAddr16];
        end
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadAbc();
        for (int i = 0; i < 16; i++) blockMsg[i] = 32'd0;
        blockMsg[0]  = 32'h61626380;
        blockMsg[15] = 32'h00000018;
    endtask

    task automatic loadRandom();
        for (int i = 0; i < 16; i++) blockMsg[i] = $urandom;
    endtask

    task automatic checkResetValues(input string who);
        checkOutput({who, " msg_ready"},   32'(oMsgReady),   32'd0);
        checkOutput({who, " round_valid"}, 32'(oRoundValid), 32'd0);
        checkOutput({who, " round_idx"},   32'(oRoundIdx),   32'd0);
        checkOutput({who, " busy"},        32'(oBusy),       32'd0);
        checkOutput({who, " done"},        32'(oDone),       32'd0);
        checkOutput({who, " rom_addr"},    32'(oRomAddr),    32'd0);
        checkOutput({who, " round_w"},     oRoundW,          32'd0);
        checkOutput({who, " round_k"},     oRoundK,          32'd0);
    endtask

    // Runs one block on the selected instance. Entered just after a rising edge
    // with the DUT in IDLE; returns at the falling edge of the first IDLE cycle
    // after DONE (or of the cycle after an abort).
    task automatic applyStimulus(input int gapMode, input int stallPct, input int stallAt, input int stallLen,
                                 input bit misuse, input int abortAt);
        logic [31:0] wExp [64];
        int          rounds, n, t, guard, stallLeft;
        logic        valid;
        rounds = sel ? 16 : 64;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) wExp[i] = blockMsg[i];
            else        wExp[i] = ssig1(wExp[i - 2]) + wExp[i - 7] + ssig0(wExp[i - 15]) + wExp[i - 16];
        end
        stallLeft = stallLen;
        w16 = 32'd0; w17 = 32'd0; lastK = 32'd0;

        if (misuse) begin
            for (int i = 0; i < 3; i++) begin
                start = 1'b0; msgValid = 1'b1; msgData = $urandom;
                @(negedge clk);
                checkOutput("idle msg_ready", 32'(oMsgReady), 32'd0);
                checkOutput("idle busy", 32'(oBusy), 32'd0);
                nextCycle();
            end
        end

        start = 1'b1; msgValid = misuse; msgData = $urandom; roundReady = 1'($urandom_range(1));
        @(negedge clk);
        checkOutput("start cycle busy", 32'(oBusy), 32'd0);
        nextCycle();

        n = 0; guard = 0;
        while (n < 16 && guard < 200) begin
            if (gapMode == 0)      valid = 1'b1;
            else if (gapMode == 1) valid = 1'((guard % 2) == 0);
            else                   valid = 1'($urandom_range(1));
            msgValid = valid;
            msgData  = valid ? blockMsg[n] : $urandom;
            start    = misuse ? 1'($urandom_range(1)) : 1'b0;
            @(negedge clk);
            checkOutput("load msg_ready", 32'(oMsgReady), 32'd1);
            checkOutput("load round_valid", 32'(oRoundValid), 32'd0);
            checkOutput("load rom_addr", 32'(oRomAddr), 32'd0);
            if (valid) n++;
            nextCycle();
            guard++;
        end
        msgValid = misuse;

        t = 0; guard = 0;
        while (t < rounds && guard < 2000) begin
            if (t == stallAt && stallLeft > 0) begin
                roundReady = 1'b0;
                stallLeft--;
            end else begin
                roundReady = 1'(int'($urandom_range(99)) >= stallPct);
            end
            start = misuse ? 1'($urandom_range(1)) : 1'b0;
            if (t == abortAt) begin
                reset = 1'b1;
                #1;
                checkResetValues("abort");
                nextCycle();
                reset = 1'b0; start = 1'b0; msgValid = 1'b0; roundReady = 1'b0;
                @(negedge clk);
                checkOutput("post-abort busy", 32'(oBusy), 32'd0);
                checkOutput("post-abort round_valid", 32'(oRoundValid), 32'd0);
                checkOutput("post-abort done", 32'(oDone), 32'd0);
                return;
            end
            @(negedge clk);
            checkOutput($sformatf("round_valid t=%0d", t), 32'(oRoundValid), 32'd1);
            checkOutput($sformatf("round msg_ready t=%0d", t), 32'(oMsgReady), 32'd0);
            checkOutput($sformatf("round done t=%0d", t), 32'(oDone), 32'd0);
            checkOutput($sformatf("round_idx t=%0d", t), 32'(oRoundIdx), 32'(t));
            checkOutput($sformatf("round_k t=%0d", t), oRoundK, K_TAB[t]);
            checkOutput($sformatf("round_w t=%0d", t), oRoundW, wExp[t]);
            checkOutput($sformatf("rom_addr t=%0d ready=%0d", t, roundReady), 32'(oRomAddr),
                        roundReady ? 32'((t + 1) % rounds) : 32'(t));
            if (t == 16) w16 = oRoundW;
            if (t == 17) w17 = oRoundW;
            if (t == rounds - 1) lastK = oRoundK;
            if (roundReady) t++;
            nextCycle();
            guard++;
        end

        start = misuse; roundReady = 1'($urandom_range(1)); msgValid = 1'($urandom_range(1));
        @(negedge clk);
        checkOutput("done pulse", 32'(oDone), 32'd1);
        checkOutput("done round_valid", 32'(oRoundValid), 32'd0);
        checkOutput("done busy", 32'(oBusy), 32'd1);
        checkOutput("done rom_addr", 32'(oRomAddr), 32'd0);
        nextCycle();
        start = 1'b0; msgValid = 1'b0;
        @(negedge clk);
        checkOutput("after done pulse", 32'(oDone), 32'd0);
        checkOutput("after done busy", 32'(oBusy), 32'd0);
        checkOutput("after done msg_ready", 32'(oMsgReady), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; msgValid = 1'b0; msgData = 32'd0; roundReady = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset64");
        sel = 1'b1;
        #1;
        checkResetValues("reset16");
        sel = 1'b0;
        nextCycle();
        reset = 1'b0;

        $display("[TB] abc block, no stalls");
        loadAbc();
        nextCycle();
        applyStimulus(0, 0, -1, 0, 1'b0, -1);
        checkOutput("abc round16 w", w16, 32'h61626380);
        checkOutput("abc round17 w", w17, 32'h000F0000);
        checkOutput("abc round63 k", lastK, 32'hc67178f2);

        $display("[TB] gapped load, random block");
        loadRandom();
        nextCycle();
        applyStimulus(1, 0, -1, 0, 1'b0, -1);

        $display("[TB] 3-cycle stall at t=5, abc block");
        loadAbc();
        nextCycle();
        applyStimulus(0, 0, 5, 3, 1'b0, -1);

        $display("[TB] reset mid-ROUND at t=30, then abc again");
        nextCycle();
        applyStimulus(0, 0, -1, 0, 1'b0, 30);
        nextCycle();
        applyStimulus(0, 0, -1, 0, 1'b0, -1);
        checkOutput("abc rerun round17 w", w17, 32'h000F0000);

        $display("[TB] protocol misuse, abc block");
        nextCycle();
        applyStimulus(0, 0, -1, 0, 1'b1, -1);

        $display("[TB] random blocks with random gaps and stalls");
        for (int b = 0; b < 4; b++) begin
            loadRandom();
            nextCycle();
            applyStimulus(2, 25, -1, 0, 1'($urandom_range(1)), -1);
        end

        $display("[TB] ROUNDS=16 instance, abc block");
        sel = 1'b1;
        loadAbc();
        nextCycle();
        applyStimulus(0, 0, -1, 0, 1'b0, -1);
        checkOutput("r16 last k", lastK, K_TAB[15]);
        // Still inside the first IDLE cycle after DONE: start here must be taken.
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        @(negedge clk);
        checkOutput("r16 restart msg_ready", 32'(oMsgReady), 32'd1);
        checkOutput("r16 restart busy", 32'(oBusy), 32'd1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
